// File: rtl/ptw_multi.sv
// Multi-slot page-table walker: up to NUM_WALKERS concurrent walks, slot-tagged PTE reads
// with out-of-order returns, large-page termination at any level and a held response channel.
module ptw_multi #(
    parameter int ADDR_W      = 48,
    parameter int PTE_W       = 64,
    parameter int LEVELS      = 4,
    parameter int INDEX_BITS  = 9,
    parameter int PAGE_SHIFT  = 12,
    parameter int NUM_WALKERS = 4,
    parameter int TAG_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_va,
    input  logic [ADDR_W-1:0]              req_root,
    input  logic [TAG_W-1:0]               req_tag,
    output logic                           mem_arvalid,
    input  logic                           mem_arready,
    output logic [ADDR_W-1:0]              mem_araddr,
    output logic [$clog2(NUM_WALKERS)-1:0] mem_arid,
    input  logic                           mem_rvalid,
    output logic                           mem_rready,
    input  logic [$clog2(NUM_WALKERS)-1:0] mem_rid,
    input  logic [PTE_W-1:0]               mem_rdata,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [TAG_W-1:0]               resp_tag,
    output logic [ADDR_W-1:0]              resp_pa,
    output logic                           resp_fault,
    output logic [2:0]                     resp_level
);

    localparam int SID_W = $clog2(NUM_WALKERS);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] PAGE_MASK = (ONE_A << PAGE_SHIFT) - ONE_A;
    localparam logic [ADDR_W-1:0] IDX_MASK  = (ONE_A << INDEX_BITS) - ONE_A;
    localparam logic [2:0]        LAST_LVL  = 3'(LEVELS - 1);

    typedef enum logic [1:0] {S_FREE, S_ISSUE, S_WAIT, S_DONE} slot_state_t;

    function automatic int level_shift(input logic [2:0] lvl);
        return PAGE_SHIFT + (LEVELS - 1 - int'(lvl)) * INDEX_BITS;
    endfunction

    function automatic logic [ADDR_W-1:0] low_mask(input logic [2:0] lvl);
        return (ONE_A << level_shift(lvl)) - ONE_A;
    endfunction

    function automatic logic [ADDR_W-1:0] pte_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] va,
                                                   input logic [2:0]        lvl);
        logic [ADDR_W-1:0] idx;
        idx = (va >> level_shift(lvl)) & IDX_MASK;
        return base + {idx[ADDR_W-4:0], 3'b000};
    endfunction

    slot_state_t       state_r     [NUM_WALKERS];
    logic [ADDR_W-1:0] va_r        [NUM_WALKERS];
    logic [ADDR_W-1:0] base_r      [NUM_WALKERS];
    logic [ADDR_W-1:0] pa_r        [NUM_WALKERS];
    logic [TAG_W-1:0]  tag_r       [NUM_WALKERS];
    logic [2:0]        level_r     [NUM_WALKERS];
    logic              fault_r     [NUM_WALKERS];

    slot_state_t       nxt_state_s [NUM_WALKERS];
    logic [ADDR_W-1:0] nxt_va_s    [NUM_WALKERS];
    logic [ADDR_W-1:0] nxt_base_s  [NUM_WALKERS];
    logic [ADDR_W-1:0] nxt_pa_s    [NUM_WALKERS];
    logic [TAG_W-1:0]  nxt_tag_s   [NUM_WALKERS];
    logic [2:0]        nxt_level_s [NUM_WALKERS];
    logic              nxt_fault_s [NUM_WALKERS];

    logic [NUM_WALKERS-1:0] free_s;
    logic [SID_W-1:0]       alloc_slot_s;
    logic                   req_fire_s;
    logic                   ar_fire_s;
    logic                   resp_fire_s;
    logic [ADDR_W-1:0]      pte_a_s;
    logic [SID_W-1:0]       last_grant_r;
    logic [SID_W-1:0]       resp_slot_r;
    logic [SID_W-1:0]       ar_cand_s;
    logic [SID_W-1:0]       ar_pick_s;
    logic                   ar_found_s;
    logic [SID_W-1:0]       resp_pick_s;
    logic                   resp_found_s;
    logic                   unused_s;

    assign mem_rready  = 1'b1;
    assign req_ready   = |free_s;
    assign req_fire_s  = req_valid & req_ready;
    assign ar_fire_s   = mem_arvalid & mem_arready;
    assign resp_fire_s = resp_valid & resp_ready;
    assign pte_a_s     = mem_rdata[ADDR_W-1:0];
    assign unused_s    = ^mem_rdata[PTE_W-1:ADDR_W];

    // Free flags and lowest-index free slot for allocation
    always_comb begin
        alloc_slot_s = '0;
        for (int i = NUM_WALKERS - 1; i >= 0; i--) begin
            free_s[i]    = (state_r[i] == S_FREE);
            alloc_slot_s = free_s[i] ? SID_W'(i) : alloc_slot_s;
        end
    end

    // Per-slot next state: allocation, AR handshake, PTE decode, response handshake
    always_comb begin
        for (int i = 0; i < NUM_WALKERS; i++) begin
            nxt_state_s[i] = state_r[i];
            nxt_va_s[i]    = va_r[i];
            nxt_base_s[i]  = base_r[i];
            nxt_pa_s[i]    = pa_r[i];
            nxt_tag_s[i]   = tag_r[i];
            nxt_level_s[i] = level_r[i];
            nxt_fault_s[i] = fault_r[i];
            case (state_r[i])
                S_FREE: begin
                    if (req_fire_s && alloc_slot_s == SID_W'(i)) begin
                        nxt_state_s[i] = S_ISSUE;
                        nxt_va_s[i]    = req_va;
                        nxt_base_s[i]  = req_root & ~PAGE_MASK;
                        nxt_tag_s[i]   = req_tag;
                        nxt_level_s[i] = 3'd0;
                        nxt_fault_s[i] = 1'b0;
                        nxt_pa_s[i]    = '0;
                    end else begin
                        nxt_state_s[i] = S_FREE;
                    end
                end
                S_ISSUE: begin
                    if (ar_fire_s && mem_arid == SID_W'(i)) begin
                        nxt_state_s[i] = S_WAIT;
                    end else begin
                        nxt_state_s[i] = S_ISSUE;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid && mem_rid == SID_W'(i)) begin
                        if (!mem_rdata[0]) begin
                            nxt_state_s[i] = S_DONE;
                            nxt_fault_s[i] = 1'b1;
                            nxt_pa_s[i]    = '0;
                        end else if (mem_rdata[1] || level_r[i] == LAST_LVL) begin
                            nxt_state_s[i] = S_DONE;
                            nxt_fault_s[i] = 1'b0;
                            nxt_pa_s[i]    = (pte_a_s & ~low_mask(level_r[i]))
                                           | (va_r[i] & low_mask(level_r[i]));
                        end else begin
                            nxt_state_s[i] = S_ISSUE;
                            nxt_base_s[i]  = pte_a_s & ~PAGE_MASK;
                            nxt_level_s[i] = level_r[i] + 3'd1;
                        end
                    end else begin
                        nxt_state_s[i] = S_WAIT;
                    end
                end
                S_DONE: begin
                    if (resp_fire_s && resp_slot_r == SID_W'(i)) begin
                        nxt_state_s[i] = S_FREE;
                    end else begin
                        nxt_state_s[i] = S_DONE;
                    end
                end
                default: nxt_state_s[i] = S_FREE;
            endcase
        end
    end

    // Arbitration works on next-cycle slot state so a fresh ISSUE slot is driven one cycle later
    always_comb begin
        ar_found_s   = 1'b0;
        ar_pick_s    = '0;
        ar_cand_s    = '0;
        resp_found_s = 1'b0;
        resp_pick_s  = '0;
        for (int k = NUM_WALKERS; k >= 1; k--) begin
            ar_cand_s  = last_grant_r + SID_W'(k);
            ar_pick_s  = (nxt_state_s[ar_cand_s] == S_ISSUE) ? ar_cand_s : ar_pick_s;
            ar_found_s = ar_found_s | (nxt_state_s[ar_cand_s] == S_ISSUE);
        end
        for (int i = NUM_WALKERS - 1; i >= 0; i--) begin
            resp_pick_s  = (nxt_state_s[i] == S_DONE) ? SID_W'(i) : resp_pick_s;
            resp_found_s = resp_found_s | (nxt_state_s[i] == S_DONE);
        end
    end

    // Slot context registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WALKERS; i++) begin
            if (rst) begin
                state_r[i] <= S_FREE;
                va_r[i]    <= '0;
                base_r[i]  <= '0;
                pa_r[i]    <= '0;
                tag_r[i]   <= '0;
                level_r[i] <= 3'd0;
                fault_r[i] <= 1'b0;
            end else begin
                state_r[i] <= nxt_state_s[i];
                va_r[i]    <= nxt_va_s[i];
                base_r[i]  <= nxt_base_s[i];
                pa_r[i]    <= nxt_pa_s[i];
                tag_r[i]   <= nxt_tag_s[i];
                level_r[i] <= nxt_level_s[i];
                fault_r[i] <= nxt_fault_s[i];
            end
        end
    end

    // Read-address channel: reload only when idle or on a handshake, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_arvalid  <= 1'b0;
            mem_araddr   <= '0;
            mem_arid     <= '0;
            last_grant_r <= SID_W'(NUM_WALKERS - 1);
        end else if (!mem_arvalid || mem_arready) begin
            mem_arvalid <= ar_found_s;
            if (ar_found_s) begin
                mem_araddr   <= pte_addr(nxt_base_s[ar_pick_s], nxt_va_s[ar_pick_s],
                                         nxt_level_s[ar_pick_s]);
                mem_arid     <= ar_pick_s;
                last_grant_r <= ar_pick_s;
            end
        end
    end

    // Response channel: payload held stable until the consumer accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid  <= 1'b0;
            resp_tag    <= '0;
            resp_pa     <= '0;
            resp_fault  <= 1'b0;
            resp_level  <= 3'd0;
            resp_slot_r <= '0;
        end else if (!resp_valid || resp_ready) begin
            resp_valid <= resp_found_s;
            if (resp_found_s) begin
                resp_tag    <= nxt_tag_s[resp_pick_s];
                resp_pa     <= nxt_pa_s[resp_pick_s];
                resp_fault  <= nxt_fault_s[resp_pick_s];
                resp_level  <= nxt_level_s[resp_pick_s];
                resp_slot_r <= resp_pick_s;
            end
        end
    end

endmodule

// File: tb/tb_ptw_multi.sv
// Directed self-checking bench for ptw_multi with a 3-level table and four walk slots.
module tb_ptw_multi;

    localparam int ADDR_W      = 48;
    localparam int PTE_W       = 64;
    localparam int LEVELS      = 3;
    localparam int INDEX_BITS  = 9;
    localparam int PAGE_SHIFT  = 12;
    localparam int NUM_WALKERS = 4;
    localparam int TAG_W       = 8;
    localparam int SID_W       = 2;
    localparam logic [ADDR_W-1:0] VA = 48'h0000_4020_1ABC;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_va;
    logic [ADDR_W-1:0] req_root;
    logic [TAG_W-1:0]  req_tag;
    logic              mem_arvalid;
    logic              mem_arready;
    logic [ADDR_W-1:0] mem_araddr;
    logic [SID_W-1:0]  mem_arid;
    logic              mem_rvalid;
    logic              mem_rready;
    logic [SID_W-1:0]  mem_rid;
    logic [PTE_W-1:0]  mem_rdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [TAG_W-1:0]  resp_tag;
    logic [ADDR_W-1:0] resp_pa;
    logic              resp_fault;
    logic [2:0]        resp_level;

    int tests_run    = 0;
    int tests_failed = 0;

    ptw_multi #(
        .ADDR_W(ADDR_W), .PTE_W(PTE_W), .LEVELS(LEVELS), .INDEX_BITS(INDEX_BITS),
        .PAGE_SHIFT(PAGE_SHIFT), .NUM_WALKERS(NUM_WALKERS), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
        .req_root(req_root), .req_tag(req_tag),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arid(mem_arid), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_rid(mem_rid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
        .resp_pa(resp_pa), .resp_fault(resp_fault), .resp_level(resp_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [ADDR_W-1:0] root, input logic [TAG_W-1:0] tag);
        req_valid = 1'b1;
        req_va    = VA;
        req_root  = root;
        req_tag   = tag;
        chk("req_ready", {63'd0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Expects an AR now (single active walk), answers it one cycle after the handshake
    task automatic walk_step(input logic [ADDR_W-1:0] exp_addr, input logic [SID_W-1:0] id,
                             input logic [PTE_W-1:0] pte, input string tag);
        chk({tag, "_arvalid"}, {63'd0, mem_arvalid}, 64'd1);
        chk({tag, "_araddr"}, {16'd0, mem_araddr}, {16'd0, exp_addr});
        chk({tag, "_arid"}, {62'd0, mem_arid}, {62'd0, id});
        tick();
        chk({tag, "_ar_drop"}, {63'd0, mem_arvalid}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rid    = id;
        mem_rdata  = pte;
        tick();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_va = '0; req_root = '0; req_tag = '0;
        mem_arready = 1'b1; mem_rvalid = 1'b0; mem_rid = '0; mem_rdata = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        chk("rst_arvalid", {63'd0, mem_arvalid}, 64'd0);
        chk("rst_araddr", {16'd0, mem_araddr}, 64'd0);
        chk("rst_arid", {62'd0, mem_arid}, 64'd0);
        chk("rst_rready", {63'd0, mem_rready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_pa", {16'd0, resp_pa}, 64'd0);
        chk("rst_resp_fault", {63'd0, resp_fault}, 64'd0);
        chk("rst_resp_level", {61'd0, resp_level}, 64'd0);
        chk("rst_resp_tag", {56'd0, resp_tag}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        rst = 1'b0;

        // Full three-level walk
        send_req(48'h1000, 8'hA5);
        walk_step(48'h1008, 2'd0, 64'h2001, "t1_l0");
        walk_step(48'h2008, 2'd0, 64'h3001, "t1_l1");
        walk_step(48'h3008, 2'd0, 64'h7_8000_0001, "t1_l2");
        chk("t1_valid", {63'd0, resp_valid}, 64'd1);
        chk("t1_pa", {16'd0, resp_pa}, 64'h7_8000_0ABC);
        chk("t1_fault", {63'd0, resp_fault}, 64'd0);
        chk("t1_level", {61'd0, resp_level}, 64'd2);
        chk("t1_tag", {56'd0, resp_tag}, 64'hA5);
        tick();
        chk("t1_done", {63'd0, resp_valid}, 64'd0);

        // Large-page leaf at level 1; root low bits must be ignored
        send_req(48'h1FFF, 8'h3C);
        walk_step(48'h1008, 2'd0, 64'h2001, "t2_l0");
        walk_step(48'h2008, 2'd0, 64'h40_0003, "t2_l1");
        chk("t2_valid", {63'd0, resp_valid}, 64'd1);
        chk("t2_pa", {16'd0, resp_pa}, 64'h40_1ABC);
        chk("t2_level", {61'd0, resp_level}, 64'd1);
        chk("t2_fault", {63'd0, resp_fault}, 64'd0);
        chk("t2_tag", {56'd0, resp_tag}, 64'h3C);
        chk("t2_no_ar", {63'd0, mem_arvalid}, 64'd0);
        tick();

        // Invalid PTE at level 1
        send_req(48'h1000, 8'h5A);
        walk_step(48'h1008, 2'd0, 64'h2001, "t3_l0");
        walk_step(48'h2008, 2'd0, 64'h0, "t3_l1");
        chk("t3_valid", {63'd0, resp_valid}, 64'd1);
        chk("t3_fault", {63'd0, resp_fault}, 64'd1);
        chk("t3_pa", {16'd0, resp_pa}, 64'd0);
        chk("t3_level", {61'd0, resp_level}, 64'd1);
        tick();
        chk("t3_freed_valid", {63'd0, resp_valid}, 64'd0);
        chk("t3_freed_ready", {63'd0, req_ready}, 64'd1);

        // Four concurrent walks with AR backpressure, reverse-order level-0 leaf returns
        mem_arready = 1'b0;
        for (int i = 0; i < 4; i++) send_req(48'(i + 1) << 16, 8'(i + 1));
        for (int c = 0; c < 5; c++) begin
            chk("t4_hold_valid", {63'd0, mem_arvalid}, 64'd1);
            chk("t4_hold_addr", {16'd0, mem_araddr}, 64'h10008);
            chk("t4_hold_id", {62'd0, mem_arid}, 64'd0);
            chk("t4_full", {63'd0, req_ready}, 64'd0);
            tick();
        end
        mem_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_rr_valid", {63'd0, mem_arvalid}, 64'd1);
            chk("t4_rr_addr", {16'd0, mem_araddr}, (64'(k + 1) << 16) + 64'd8);
            chk("t4_rr_id", {62'd0, mem_arid}, 64'(k));
            tick();
        end
        chk("t4_ar_idle", {63'd0, mem_arvalid}, 64'd0);
        for (int k = 3; k >= 0; k--) begin
            mem_rvalid = 1'b1;
            mem_rid    = 2'(k);
            mem_rdata  = (64'(k + 1) << 30) | 64'd3;
            tick();
            chk("t4_resp_valid", {63'd0, resp_valid}, 64'd1);
            chk("t4_resp_tag", {56'd0, resp_tag}, 64'(k + 1));
            chk("t4_resp_pa", {16'd0, resp_pa}, (64'(k + 1) << 30) | 64'h20_1ABC);
            chk("t4_resp_level", {61'd0, resp_level}, 64'd0);
            if (k == 3) chk("t4_still_full", {63'd0, req_ready}, 64'd0);
            if (k == 2) chk("t4_slot_free", {63'd0, req_ready}, 64'd1);
        end
        mem_rvalid = 1'b0;
        tick();
        chk("t4_drained", {63'd0, resp_valid}, 64'd0);

        // Two walks DONE while the consumer stalls
        resp_ready = 1'b0;
        send_req(48'h10000, 8'h51);
        send_req(48'h20000, 8'h52);
        chk("t5_ar1_addr", {16'd0, mem_araddr}, 64'h20008);
        chk("t5_ar1_id", {62'd0, mem_arid}, 64'd1);
        tick();
        mem_rvalid = 1'b1; mem_rid = 2'd0; mem_rdata = (64'd1 << 30) | 64'd3;
        tick();
        mem_rid = 2'd1; mem_rdata = (64'd2 << 30) | 64'd3;
        tick();
        mem_rvalid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("t5_hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("t5_hold_tag", {56'd0, resp_tag}, 64'h51);
            chk("t5_hold_pa", {16'd0, resp_pa}, 64'h4020_1ABC);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("t5_second_valid", {63'd0, resp_valid}, 64'd1);
        chk("t5_second_tag", {56'd0, resp_tag}, 64'h52);
        chk("t5_second_pa", {16'd0, resp_pa}, 64'h8020_1ABC);
        tick();
        chk("t5_drained", {63'd0, resp_valid}, 64'd0);

        // Reset with two slots waiting, then a stale return
        send_req(48'h10000, 8'h61);
        send_req(48'h20000, 8'h62);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_req_ready", {63'd0, req_ready}, 64'd1);
        chk("t6_arvalid", {63'd0, mem_arvalid}, 64'd0);
        chk("t6_resp_valid", {63'd0, resp_valid}, 64'd0);
        mem_rvalid = 1'b1; mem_rid = 2'd0; mem_rdata = (64'd1 << 30) | 64'd3;
        tick();
        mem_rvalid = 1'b0;
        chk("t6_stale_resp", {63'd0, resp_valid}, 64'd0);
        chk("t6_stale_ar", {63'd0, mem_arvalid}, 64'd0);
        send_req(48'h1000, 8'h7E);
        walk_step(48'h1008, 2'd0, 64'h2001, "t6_l0");
        walk_step(48'h2008, 2'd0, 64'h3001, "t6_l1");
        walk_step(48'h3008, 2'd0, 64'h7_8000_0001, "t6_l2");
        chk("t6_pa", {16'd0, resp_pa}, 64'h7_8000_0ABC);
        chk("t6_tag", {56'd0, resp_tag}, 64'h7E);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ptw_multi.md
Name: ptw_multi

Overview:
- Multi-slot, parametrised page-table walker between the TLB miss path and the memory read port.
- Holds up to NUM_WALKERS independent walks at once.
- Issues PTE reads tagged by slot ID and accepts out-of-order read returns.
- Supports a per-request root table base, leaf (large-page) termination at any level, and a backpressured response channel.

Parameters:
- ADDR_W, 48, virtual/physical address width
- PTE_W, 64, PTE/read-data width (≥ ADDR_W)
- LEVELS, 4, page-table levels (1..6); level 0 = root
- INDEX_BITS, 9, VA index bits per level
- PAGE_SHIFT, 12, base page offset bits
- NUM_WALKERS, 4, concurrent walk slots (power of two, ≥2)
- TAG_W, 8, requester tag width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  walk request
- req_ready  out  1  a free slot exists
- req_va  in  ADDR_W  virtual address
- req_root  in  ADDR_W  root table base (low PAGE_SHIFT bits ignored)
- req_tag  in  TAG_W  requester tag, returned unchanged
- mem_arvalid  out  1  PTE read request
- mem_arready  in  1  read request accepted
- mem_araddr  out  ADDR_W  PTE address
- mem_arid  out  clog2(NUM_WALKERS)  slot ID
- mem_rvalid  in  1  read data valid
- mem_rready  out  1  tied 1
- mem_rid  in  clog2(NUM_WALKERS)  slot ID of returned data
- mem_rdata  in  PTE_W  PTE
- resp_valid  out  1  walk result
- resp_ready  in  1  consumer accepts
- resp_tag  out  TAG_W  tag of completed walk
- resp_pa  out  ADDR_W  physical address (0 on fault)
- resp_fault  out  1  walk faulted
- resp_level  out  3  level of terminating PTE

Behaviour:
- Reset: every slot FREE; mem_arvalid=0; mem_araddr=0; mem_arid=0; resp_valid=0; resp_pa=0; resp_fault=0; resp_level=0; resp_tag=0. mem_rready is 1 during and after reset.
- Slot states: FREE, ISSUE, WAIT, DONE.
- req_ready is combinational: OR of the registered FREE flags. On req_valid&req_ready, the lowest-index FREE slot latches va, root (as table base), tag, level=0, and enters ISSUE.
- A slot freed in cycle T is not visible to req_ready until T+1.
- Index at level l: va[s_l +: INDEX_BITS], where s_l = PAGE_SHIFT + (LEVELS-1-l)*INDEX_BITS.
- PTE address = {base[ADDR_W-1:PAGE_SHIFT], PAGE_SHIFT'b0} + index*8, truncated to ADDR_W.
- AR arbitration:
  - Round-robin among ISSUE slots, starting after the last granted slot.
  - mem_arvalid/araddr/arid are registered.
  - Once mem_arvalid=1, these outputs stay stable until mem_arready.
  - On the handshake the slot moves ISSUE→WAIT.
  - A new AR may be driven the cycle after a handshake.
- Read return (mem_rvalid) targets slot mem_rid; data is ignored if that slot is not in WAIT. PTE decode:
  - bit0=0 → DONE, fault=1, pa=0, level=l.
  - bit0=1 and (bit1=1 or l==LEVELS-1) → DONE, fault=0, level=l, pa = {pte[ADDR_W-1:s_l], va[s_l-1:0]}.
  - Otherwise → base=pte[ADDR_W-1:PAGE_SHIFT], level=l+1, ISSUE.
  - Returns may complete the same cycle another slot wins AR arbitration; both take effect.
- Response:
  - The lowest-index DONE slot drives resp_* (registered), holding resp_valid and the payload stable until resp_ready.
  - On resp_valid&resp_ready the slot goes FREE. The next DONE slot's resp_valid may assert the following cycle.
- Latency (arready=1, single slot): accept at T; AR valid at T+1. If rvalid arrives k cycles after the AR handshake, the next AR or resp_valid is 1 cycle after rvalid. Per level: 1 + memory latency + 1.
- rst mid-walk returns all slots to FREE immediately.
  - Late read returns are dropped unless that slot has re-entered WAIT.
  - The integrator must drain memory before deasserting rst.

Test Plan:
- LEVELS=3, INDEX_BITS=9, PAGE_SHIFT=12; va=0x40201ABC, root=0x1000.
  - AR addresses must be 0x1008, 0x2008, 0x3008.
  - Supply PTEs 0x2001, 0x3001, 0x780000001.
  - Required: resp_pa=0x780000ABC, fault=0, level=2, tag echoed.
- Same va, level-1 PTE=0x400003 (leaf) → only 2 ARs; resp_pa=0x401ABC, level=1.
- Same va, level-1 PTE=0x0 → resp_fault=1, resp_pa=0, level=1; slot freed after resp handshake.
- Four walks with tags 1..4 and arready held low 5 cycles:
  - arvalid/araddr stay stable throughout.
  - Grants are round-robin.
  - Returns arrive in reverse slot order; all four responses carry correct tag/pa.
  - A fifth request sees req_ready=0 until a response handshake.
- resp_ready held low 10 cycles with two walks DONE → resp_* stable; lower slot delivered first, second one cycle after the handshake.
- rst asserted while two slots are in WAIT → next cycle req_ready=1, arvalid=0, resp_valid=0; a stale rvalid with rid=0 is ignored.
